// File: rtl/myproject_sdiv_23s_7s_16_seq.sv
// Sequential signed divider: 23-bit signed dividend / 7-bit signed divisor -> 16-bit
// saturated signed quotient and 7-bit signed remainder. Radix-2 restoring division on
// magnitudes, one quotient bit per cycle, wrapped in an ap_start/ap_done handshake.
module myproject_sdiv_23s_7s_16_seq #(
    parameter int DIVIDEND_W = 23,
    parameter int DIVISOR_W  = 7,
    parameter int QUOT_W     = 16
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        ap_start,
    output logic                        ap_idle,
    output logic                        ap_ready,
    output logic                        ap_done,
    input  logic signed [DIVIDEND_W-1:0] din0,
    input  logic signed [DIVISOR_W-1:0]  din1,
    output logic signed [QUOT_W-1:0]     dout,
    output logic signed [DIVISOR_W-1:0]  rem,
    output logic                        ovf,
    output logic                        dbz
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    // Saturation bounds of the signed quotient, as bit patterns.
    localparam logic [QUOT_W-1:0] Q_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0] Q_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

    // Largest quotient magnitudes representable for a positive / negative result.
    localparam logic [DIVIDEND_W-1:0] POS_LIM = {{(DIVIDEND_W-QUOT_W){1'b0}}, Q_MAX};
    localparam logic [DIVIDEND_W-1:0] NEG_LIM = {{(DIVIDEND_W-QUOT_W){1'b0}}, Q_MIN};

    localparam logic [DIVIDEND_W-1:0] ONE_D  = {{(DIVIDEND_W-1){1'b0}}, 1'b1};
    localparam logic [DIVISOR_W-1:0]  ONE_R  = {{(DIVISOR_W-1){1'b0}}, 1'b1};
    localparam logic [QUOT_W-1:0]     ONE_Q  = {{(QUOT_W-1){1'b0}}, 1'b1};
    localparam logic [DIVISOR_W-1:0]  ZERO_R = {DIVISOR_W{1'b0}};
    localparam logic [DIVIDEND_W-1:0] ZERO_D = {DIVIDEND_W{1'b0}};
    localparam logic [QUOT_W-1:0]     ZERO_Q = {QUOT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(DIVIDEND_W - 1);
    localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Magnitude of the dividend; -2^(W-1) maps to 2^(W-1), which still fits unsigned.
    function automatic logic [DIVIDEND_W-1:0] abs_dvd(input logic [DIVIDEND_W-1:0] v);
        if (v[DIVIDEND_W-1]) begin
            abs_dvd = ~v + ONE_D;
        end else begin
            abs_dvd = v;
        end
    endfunction

    // Magnitude of the divisor; -64 maps to 64 in the 7-bit unsigned result.
    function automatic logic [DIVISOR_W-1:0] abs_dvs(input logic [DIVISOR_W-1:0] v);
        if (v[DIVISOR_W-1]) begin
            abs_dvs = ~v + ONE_R;
        end else begin
            abs_dvs = v;
        end
    endfunction

    // Two's complement negation at quotient width.
    function automatic logic [QUOT_W-1:0] neg_quo(input logic [QUOT_W-1:0] v);
        neg_quo = ~v + ONE_Q;
    endfunction

    // Two's complement negation at remainder width.
    function automatic logic [DIVISOR_W-1:0] neg_rem(input logic [DIVISOR_W-1:0] v);
        neg_rem = ~v + ONE_R;
    endfunction

    state_t                  state_r;
    logic [DIVIDEND_W-1:0]   dvd_r;      // dividend magnitude, shifted out MSB first
    logic [DIVISOR_W-1:0]    dvs_r;      // divisor magnitude
    logic [DIVISOR_W-1:0]    pr_r;       // partial remainder, always < divisor magnitude
    logic [DIVIDEND_W-1:0]   quo_r;      // unsigned quotient magnitude
    logic [CNT_W-1:0]        cnt_r;
    logic                    sign0_r;
    logic                    sign1_r;
    logic                    zero_r;
    logic [QUOT_W-1:0]       dout_r;
    logic [DIVISOR_W-1:0]    rem_r;
    logic                    ovf_r;
    logic                    dbz_r;
    logic                    ap_done_r;
    logic                    ap_idle_r;

    logic [DIVISOR_W:0]      pr_shift_s;
    logic [DIVISOR_W:0]      diff_s;
    logic                    fits_s;
    logic [DIVISOR_W-1:0]    pr_next_s;
    logic [QUOT_W-1:0]       fix_dout_s;
    logic [DIVISOR_W-1:0]    fix_rem_s;
    logic                    fix_ovf_s;

    // One restoring step: the borrow out of the trial subtraction decides the quotient bit.
    always_comb begin
        pr_shift_s = {pr_r, dvd_r[DIVIDEND_W-1]};
        diff_s     = pr_shift_s - {1'b0, dvs_r};
        fits_s     = ~diff_s[DIVISOR_W];
        if (fits_s) begin
            pr_next_s = diff_s[DIVISOR_W-1:0];
        end else begin
            pr_next_s = pr_shift_s[DIVISOR_W-1:0];
        end
    end

    // Sign restoration and saturation of the finished magnitudes.
    always_comb begin
        fix_dout_s = Q_MAX;
        fix_rem_s  = ZERO_R;
        fix_ovf_s  = 1'b0;
        if (zero_r) begin
            // Divide by zero saturates toward the dividend's sign but is not an overflow.
            if (sign0_r) begin
                fix_dout_s = Q_MIN;
            end else begin
                fix_dout_s = Q_MAX;
            end
        end else if (sign0_r ^ sign1_r) begin
            if (quo_r > NEG_LIM) begin
                fix_dout_s = Q_MIN;
                fix_ovf_s  = 1'b1;
            end else begin
                fix_dout_s = neg_quo(quo_r[QUOT_W-1:0]);
            end
        end else begin
            if (quo_r > POS_LIM) begin
                fix_dout_s = Q_MAX;
                fix_ovf_s  = 1'b1;
            end else begin
                fix_dout_s = quo_r[QUOT_W-1:0];
            end
        end
        if (zero_r) begin
            fix_rem_s = ZERO_R;
        end else if (sign0_r) begin
            fix_rem_s = neg_rem(pr_r);
        end else begin
            fix_rem_s = pr_r;
        end
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_r   <= ST_IDLE;
            dvd_r     <= ZERO_D;
            dvs_r     <= ZERO_R;
            pr_r      <= ZERO_R;
            quo_r     <= ZERO_D;
            cnt_r     <= CNT_ZERO;
            sign0_r   <= 1'b0;
            sign1_r   <= 1'b0;
            zero_r    <= 1'b0;
            dout_r    <= ZERO_Q;
            rem_r     <= ZERO_R;
            ovf_r     <= 1'b0;
            dbz_r     <= 1'b0;
            ap_done_r <= 1'b0;
            ap_idle_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ap_done_r <= 1'b0;
                    if (ap_start) begin
                        dvd_r     <= abs_dvd(din0);
                        dvs_r     <= abs_dvs(din1);
                        pr_r      <= ZERO_R;
                        quo_r     <= ZERO_D;
                        cnt_r     <= CNT_LOAD;
                        sign0_r   <= din0[DIVIDEND_W-1];
                        sign1_r   <= din1[DIVISOR_W-1];
                        zero_r    <= (din1 == ZERO_R);
                        ap_idle_r <= 1'b0;
                        state_r   <= ST_CALC;
                    end else begin
                        ap_idle_r <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    dvd_r <= {dvd_r[DIVIDEND_W-2:0], 1'b0};
                    pr_r  <= pr_next_s;
                    quo_r <= {quo_r[DIVIDEND_W-2:0], fits_s};
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_FIX;
                    end else begin
                        cnt_r   <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        state_r <= ST_CALC;
                    end
                end
                ST_FIX: begin
                    dout_r    <= fix_dout_s;
                    rem_r     <= fix_rem_s;
                    ovf_r     <= fix_ovf_s;
                    dbz_r     <= zero_r;
                    ap_done_r <= 1'b1;
                    state_r   <= ST_DONE;
                end
                ST_DONE: begin
                    ap_done_r <= 1'b0;
                    ap_idle_r <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    ap_done_r <= 1'b0;
                    ap_idle_r <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign ap_idle  = ap_idle_r;
    assign ap_ready = ap_idle_r & ap_start;
    assign ap_done  = ap_done_r;
    assign dout     = dout_r;
    assign rem      = rem_r;
    assign ovf      = ovf_r;
    assign dbz      = dbz_r;

endmodule

// File: tb/tb_myproject_sdiv_23s_7s_16_seq.sv
// Directed bench for the sequential signed divider: reset, signs, saturation,
// divide by zero, reset abort and back-to-back operation with held ap_start.
module tb_myproject_sdiv_23s_7s_16_seq;

    // ap_done is seen after the 24th rising edge following the acceptance edge
    // (acceptance cycle 0, done cycle 25).
    localparam int LAT_EDGES = 24;
    localparam int OP_PERIOD = 26;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n;
    logic               ap_start;
    logic               ap_idle;
    logic               ap_ready;
    logic               ap_done;
    logic signed [22:0] din0;
    logic signed [6:0]  din1;
    logic signed [15:0] dout;
    logic signed [6:0]  rem;
    logic               ovf;
    logic               dbz;

    int checks = 0;
    int errors = 0;

    myproject_sdiv_23s_7s_16_seq dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .ap_idle  (ap_idle),
        .ap_ready (ap_ready),
        .ap_done  (ap_done),
        .din0     (din0),
        .din1     (din1),
        .dout     (dout),
        .rem      (rem),
        .ovf      (ovf),
        .dbz      (dbz)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic wait_cycle();
        @(posedge ap_clk);
        #1;
    endtask

    // Issues one operation and returns edges from acceptance to ap_done (-1 on timeout).
    task automatic do_op(input logic [22:0] a, input logic [6:0] b, output int lat);
        int guard;
        guard = 0;
        while (!ap_idle && guard < 40) begin
            wait_cycle();
            guard++;
        end
        din0     = a;
        din1     = b;
        ap_start = 1'b1;
        wait_cycle();
        ap_start = 1'b0;
        din0     = ~a;
        din1     = ~b;
        lat      = -1;
        for (int i = 1; i <= 40; i++) begin
            wait_cycle();
            if (ap_done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        din0     = 23'sd0;
        din1     = 7'sd0;
        #12;
        ap_rst_n = 1'b1;
        wait_cycle();
        checks++; if (dout !== 16'sd0) begin errors++; $display("FAIL reset_dout: got %0d expected 0", dout); end
        checks++; if (rem !== 7'sd0) begin errors++; $display("FAIL reset_rem: got %0d expected 0", rem); end
        checks++; if ({ovf, dbz, ap_done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {ovf, dbz, ap_done}); end
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", ap_idle); end
    endtask

    task automatic test_basic();
        int lat;
        do_op(23'sd1000, 7'sd7, lat);
        checks++; if (lat != LAT_EDGES) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT_EDGES); end
        checks++; if (dout !== 16'sd142) begin errors++; $display("FAIL basic_dout: got %0d expected 142", dout); end
        checks++; if (rem !== 7'sd6) begin errors++; $display("FAIL basic_rem: got %0d expected 6", rem); end
        checks++; if ({ovf, dbz} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b expected 00", {ovf, dbz}); end
        wait_cycle();
        checks++; if (ap_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", ap_done); end
        checks++; if (dout !== 16'sd142) begin errors++; $display("FAIL basic_hold: got %0d expected 142", dout); end
    endtask

    task automatic test_signs();
        int lat;
        do_op(-23'sd1000, 7'sd7, lat);
        checks++; if (dout !== -16'sd142) begin errors++; $display("FAIL neg_dvd_dout: got %0d expected -142", dout); end
        checks++; if (rem !== -7'sd6) begin errors++; $display("FAIL neg_dvd_rem: got %0d expected -6", rem); end
        do_op(23'sd100, 7'h40, lat);
        checks++; if (dout !== -16'sd1) begin errors++; $display("FAIL neg_dvs_dout: got %0d expected -1", dout); end
        checks++; if (rem !== 7'sd36) begin errors++; $display("FAIL neg_dvs_rem: got %0d expected 36", rem); end
        checks++; if ({ovf, dbz} !== 2'b00) begin errors++; $display("FAIL neg_dvs_flags: got %b expected 00", {ovf, dbz}); end
    endtask

    task automatic test_saturation();
        int lat;
        do_op(23'h3FFFFF, 7'sd1, lat);
        checks++; if (dout !== 16'sh7FFF) begin errors++; $display("FAIL sat_pos_dout: got %0d expected 32767", dout); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_pos_ovf: got %b expected 1", ovf); end
        do_op(23'h400000, 7'h7F, lat);
        checks++; if (dout !== 16'sh7FFF) begin errors++; $display("FAIL sat_minneg_dout: got %0d expected 32767", dout); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_minneg_ovf: got %b expected 1", ovf); end
        checks++; if (rem !== 7'sd0) begin errors++; $display("FAIL sat_minneg_rem: got %0d expected 0", rem); end
        do_op(-23'sd32768, 7'sd1, lat);
        checks++; if (dout !== 16'sh8000) begin errors++; $display("FAIL edge_min_dout: got %0d expected -32768", dout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL edge_min_ovf: got %b expected 0", ovf); end
        do_op(-23'sd32769, 7'sd1, lat);
        checks++; if ({dout, ovf} !== {16'sh8000, 1'b1}) begin errors++; $display("FAIL sat_neg: got %0d/%b expected -32768/1", dout, ovf); end
    endtask

    task automatic test_div_by_zero();
        int lat;
        do_op(23'sd5, 7'sd0, lat);
        checks++; if (lat != LAT_EDGES) begin errors++; $display("FAIL dbz_latency: got %0d expected %0d", lat, LAT_EDGES); end
        checks++; if (dout !== 16'sh7FFF) begin errors++; $display("FAIL dbz_pos_dout: got %0d expected 32767", dout); end
        checks++; if ({rem, ovf, dbz} !== {7'sd0, 1'b0, 1'b1}) begin errors++; $display("FAIL dbz_pos_flags: got rem=%0d ovf=%b dbz=%b expected 0/0/1", rem, ovf, dbz); end
        do_op(-23'sd5, 7'sd0, lat);
        checks++; if (dout !== 16'sh8000) begin errors++; $display("FAIL dbz_neg_dout: got %0d expected -32768", dout); end
        checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL dbz_neg_dbz: got %b expected 1", dbz); end
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        din0     = 23'sd1000;
        din1     = 7'sd7;
        ap_start = 1'b1;
        wait_cycle();
        ap_start = 1'b0;
        repeat (9) wait_cycle();
        ap_rst_n = 1'b0;
        #2;
        checks++; if (dout !== 16'sd0) begin errors++; $display("FAIL abort_dout: got %0d expected 0", dout); end
        checks++; if ({rem, ovf, dbz, ap_done} !== 10'd0) begin errors++; $display("FAIL abort_outputs: got rem=%0d ovf=%b dbz=%b done=%b expected zeros", rem, ovf, dbz, ap_done); end
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL abort_idle: got %b expected 1", ap_idle); end
        ap_rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            wait_cycle();
            if (ap_done) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses expected 0", seen); end
        do_op(-23'sd7, 7'sd7, lat);
        checks++; if (lat != LAT_EDGES) begin errors++; $display("FAIL abort_next_latency: got %0d expected %0d", lat, LAT_EDGES); end
        checks++; if ({dout, rem} !== {-16'sd1, 7'sd0}) begin errors++; $display("FAIL abort_next_result: got %0d r %0d expected -1 r 0", dout, rem); end
    endtask

    task automatic test_back_to_back();
        logic [22:0] a_tab [3];
        logic [6:0]  b_tab [3];
        logic [15:0] q_tab [3];
        logic [6:0]  r_tab [3];
        int issued;
        int got;
        int last_done;
        a_tab[0] = 23'sd1000;  b_tab[0] = 7'sd7;  q_tab[0] = 16'sd142;  r_tab[0] = 7'sd6;
        a_tab[1] = -23'sd1000; b_tab[1] = 7'sd7;  q_tab[1] = -16'sd142; r_tab[1] = -7'sd6;
        a_tab[2] = 23'sd100;   b_tab[2] = 7'h40;  q_tab[2] = -16'sd1;   r_tab[2] = 7'sd36;
        issued    = 0;
        got       = 0;
        last_done = -1;
        for (int cyc = 0; cyc < 120 && got < 3; cyc++) begin
            ap_start = (issued < 3);
            #1;
            if (ap_ready) begin
                din0 = a_tab[issued];
                din1 = b_tab[issued];
                issued++;
            end else begin
                din0 = 23'($urandom());
                din1 = 7'($urandom());
            end
            wait_cycle();
            if (ap_done) begin
                checks++;
                if ({dout, rem} !== {q_tab[got], r_tab[got]}) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got %0d r %0d expected %0d r %0d", got, dout, rem, $signed(q_tab[got]), $signed(r_tab[got]));
                end
                if (last_done >= 0) begin
                    checks++;
                    if (cyc - last_done != OP_PERIOD) begin
                        errors++;
                        $display("FAIL b2b_spacing%0d: got %0d expected %0d", got, cyc - last_done, OP_PERIOD);
                    end
                end
                last_done = cyc;
                got++;
            end
        end
        ap_start = 1'b0;
        checks++; if (got != 3) begin errors++; $display("FAIL b2b_count: got %0d done pulses expected 3", got); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_saturation();
        test_div_by_zero();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
